// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared op codes, FunSel codes, sequencer states and defaults for regfile_ctrl
package regfile_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDI  = 3'b001,
        OP_MOV  = 3'b010,
        OP_INC  = 3'b011,
        OP_DEC  = 3'b100,
        OP_CLR  = 3'b101,
        OP_SWAP = 3'b110,
        OP_READ = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        FS_DEC  = 3'b000,
        FS_INC  = 3'b001,
        FS_LOAD = 3'b010,
        FS_CLR  = 3'b011
    } funsel_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_SW1  = 3'd2,
        ST_SW2  = 3'd3,
        ST_SW3  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    localparam int         DEFAULT_DATA_W  = 16;
    localparam logic [2:0] DEFAULT_TMP_IDX = 3'd7;

    // A swap touching the temporary register would clobber its own staging value.
    function automatic logic swap_conflict(input logic [2:0] dst, input logic [2:0] src,
                                           input logic [2:0] tmp);
        return (dst == tmp) || (src == tmp);
    endfunction

endpackage

// File: rtl/regfile_sel_decode.sv
// rtl/regfile_sel_decode.sv - index plus write strobe to active-low RegSel/ScrSel enable pair
module regfile_sel_decode (
    input  logic [2:0] i_idx,
    input  logic       i_we,
    output logic [3:0] o_reg_sel,
    output logic [3:0] o_scr_sel
);

    // Index 0 maps to bit 3 within each bank.
    always_comb begin
        o_reg_sel = 4'b1111;
        o_scr_sel = 4'b1111;
        if (i_we) begin
            if (i_idx[2]) begin
                o_scr_sel[2'd3 - i_idx[1:0]] = 1'b0;
            end else begin
                o_reg_sel[2'd3 - i_idx[1:0]] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - command sequencer driving register-file controls; REGFILE_CTRL_PERF_EN adds CmdCount
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int         DATA_W  = DEFAULT_DATA_W,
    parameter logic [2:0] TMP_IDX = DEFAULT_TMP_IDX
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [2:0]        CmdOp,
    input  logic [2:0]        CmdDst,
    input  logic [2:0]        CmdSrc,
    input  logic [DATA_W-1:0] CmdImm,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] RdData,
    output logic [DATA_W-1:0] RF_I,
    output logic [2:0]        RF_FunSel,
    output logic [3:0]        RF_RegSel,
    output logic [3:0]        RF_ScrSel,
    output logic [2:0]        RF_OutASel,
    output logic [2:0]        RF_OutBSel,
    input  logic [DATA_W-1:0] RF_OutA
`ifdef REGFILE_CTRL_PERF_EN
    ,
    output logic [15:0]       CmdCount
`endif
);

    state_e            r_state;
    state_e            w_next;
    op_e               r_op;
    logic [2:0]        r_dst;
    logic [2:0]        r_src;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_rd_data;
    logic              w_accept;
    logic              w_swap_go;
    logic              w_we;
    logic [2:0]        w_idx;
    funsel_e           w_funsel;

    assign CmdReady  = (r_state == ST_IDLE) && !Reset;
    assign w_accept  = CmdValid && CmdReady;
    assign w_swap_go = (op_e'(CmdOp) == OP_SWAP) && (CmdDst != CmdSrc)
                       && !swap_conflict(CmdDst, CmdSrc, TMP_IDX);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_op      <= OP_NOP;
            r_dst     <= '0;
            r_src     <= '0;
            r_imm     <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= op_e'(CmdOp);
                r_dst <= CmdDst;
                r_src <= CmdSrc;
                r_imm <= CmdImm;
            end
            if ((r_state == ST_EXEC) && (r_op == OP_READ)) begin
                r_rd_data <= RF_OutA;
            end
        end
    end

    // A valid swap skips EXEC so its three writes start right after acceptance.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_swap_go ? ST_SW1 : ST_EXEC;
            ST_EXEC: w_next = ST_DONE;
            ST_SW1:  w_next = ST_SW2;
            ST_SW2:  w_next = ST_SW3;
            ST_SW3:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_we       = 1'b0;
        w_idx      = r_dst;
        w_funsel   = FS_LOAD;
        RF_OutASel = 3'd0;
        RF_I       = '0;
        case (r_state)
            ST_EXEC: begin
                case (r_op)
                    OP_LDI:  begin w_we = 1'b1; RF_I = r_imm; end
                    OP_MOV:  begin w_we = 1'b1; RF_OutASel = r_src; RF_I = RF_OutA; end
                    OP_INC:  begin w_we = 1'b1; w_funsel = FS_INC; end
                    OP_DEC:  begin w_we = 1'b1; w_funsel = FS_DEC; end
                    OP_CLR:  begin w_we = 1'b1; w_funsel = FS_CLR; end
                    OP_READ: RF_OutASel = r_src;
                    default: ;
                endcase
            end
            ST_SW1: begin w_we = 1'b1; w_idx = TMP_IDX; RF_OutASel = r_src;   RF_I = RF_OutA; end
            ST_SW2: begin w_we = 1'b1; w_idx = r_src;   RF_OutASel = r_dst;   RF_I = RF_OutA; end
            ST_SW3: begin w_we = 1'b1; w_idx = r_dst;   RF_OutASel = TMP_IDX; RF_I = RF_OutA; end
            default: ;
        endcase
    end

    assign RF_FunSel  = w_funsel;
    assign RF_OutBSel = r_dst;
    assign RdData     = r_rd_data;
    assign Done       = (r_state == ST_DONE);
    assign Err        = Done && (r_op == OP_SWAP) && swap_conflict(r_dst, r_src, TMP_IDX);

    // Reset gates the strobe so an aborted command cannot land a write on the reset edge.
    regfile_sel_decode u_sel_decode (
        .i_idx     (w_idx),
        .i_we      (w_we && !Reset),
        .o_reg_sel (RF_RegSel),
        .o_scr_sel (RF_ScrSel)
    );

`ifdef REGFILE_CTRL_PERF_EN
    logic [15:0] r_cmd_count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cmd_count <= '0;
        end else if (Done && !Err && (r_cmd_count != 16'hFFFF)) begin
            r_cmd_count <= r_cmd_count + 16'd1;
        end
    end

    assign CmdCount = r_cmd_count;
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb/tb_regfile_ctrl.sv - self-checking bench for regfile_ctrl with a register-file model and reference model
module tb_regfile_ctrl;

    localparam logic [2:0] NOP = 3'd0, LDI = 3'd1, MOV = 3'd2, INC = 3'd3;
    localparam logic [2:0] DEC = 3'd4, CLR = 3'd5, SWP = 3'd6, RD  = 3'd7;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        CmdValid;
    logic        CmdReady;
    logic [2:0]  CmdOp, CmdDst, CmdSrc;
    logic [15:0] CmdImm;
    logic        Done, Err;
    logic [15:0] RdData, RF_I, RF_OutA;
    logic [2:0]  RF_FunSel, RF_OutASel, RF_OutBSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
`ifdef REGFILE_CTRL_PERF_EN
    logic [15:0] CmdCount;
`endif

    always #5 Clock = ~Clock;

    regfile_ctrl dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .CmdValid   (CmdValid),
        .CmdReady   (CmdReady),
        .CmdOp      (CmdOp),
        .CmdDst     (CmdDst),
        .CmdSrc     (CmdSrc),
        .CmdImm     (CmdImm),
        .Done       (Done),
        .Err        (Err),
        .RdData     (RdData),
        .RF_I       (RF_I),
        .RF_FunSel  (RF_FunSel),
        .RF_RegSel  (RF_RegSel),
        .RF_ScrSel  (RF_ScrSel),
        .RF_OutASel (RF_OutASel),
        .RF_OutBSel (RF_OutBSel),
        .RF_OutA    (RF_OutA)
`ifdef REGFILE_CTRL_PERF_EN
        ,
        .CmdCount   (CmdCount)
`endif
    );

    // Register file as the controller sees it: applies whatever enables it is given.
    logic [15:0] rf_mem [8];
    logic        rf_init;

    function automatic logic [15:0] rf_fn(input logic [2:0] fs, input logic [15:0] cur,
                                          input logic [15:0] d);
        case (fs)
            3'b000:  return cur - 16'd1;
            3'b001:  return cur + 16'd1;
            3'b010:  return d;
            3'b011:  return 16'd0;
            default: return cur;
        endcase
    endfunction

    always @(posedge Clock) begin
        if (rf_init) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 16'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (RF_RegSel[3-i] == 1'b0) rf_mem[i]   <= rf_fn(RF_FunSel, rf_mem[i], RF_I);
                if (RF_ScrSel[3-i] == 1'b0) rf_mem[4+i] <= rf_fn(RF_FunSel, rf_mem[4+i], RF_I);
            end
        end
    end

    assign RF_OutA = rf_mem[RF_OutASel];

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_rf [8];
    logic [15:0] rd_exp;
    int          perf_exp;

    logic [3:0]  tr_reg [11];
    logic [3:0]  tr_scr [11];
    logic [2:0]  tr_fun [11];
    logic [2:0]  tr_oa  [11];
    logic [15:0] tr_i   [11];
    logic        tr_rdy [11];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 8; i++) check($sformatf("%s.rf%0d", tag, i), rf_mem[i], ref_rf[i]);
    endtask

    // Architectural effect of one command on the eight registers.
    task automatic model(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                         input logic [15:0] imm, output int lat, output logic err);
        logic [15:0] t;
        lat = 2;
        err = 1'b0;
        case (op)
            LDI: ref_rf[dst] = imm;
            MOV: ref_rf[dst] = ref_rf[src];
            INC: ref_rf[dst] = ref_rf[dst] + 16'd1;
            DEC: ref_rf[dst] = ref_rf[dst] - 16'd1;
            CLR: ref_rf[dst] = 16'd0;
            RD:  rd_exp = ref_rf[src];
            SWP: begin
                if (dst == 3'd7 || src == 3'd7) begin
                    err = 1'b1;
                end else if (dst != src) begin
                    t = ref_rf[src];
                    ref_rf[src] = ref_rf[dst];
                    ref_rf[dst] = t;
                    ref_rf[7] = t;
                    lat = 4;
                end
            end
            default: ;
        endcase
        if (!err) perf_exp++;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                        input logic [15:0] imm, output int lat, output logic err);
        int guard = 0;
        CmdValid = 1'b1;
        CmdOp = op; CmdDst = dst; CmdSrc = src; CmdImm = imm;
        while (CmdReady !== 1'b1 && guard < 20) begin
            @(negedge Clock);
            guard++;
        end
        if (guard >= 20) check("accept_timeout", CmdReady, 1);
        @(posedge Clock);
        #1;
        CmdValid = 1'b0;
        CmdOp = 3'($urandom); CmdDst = 3'($urandom); CmdSrc = 3'($urandom); CmdImm = 16'($urandom);
        lat = 0;
        err = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clock);
            tr_reg[k] = RF_RegSel; tr_scr[k] = RF_ScrSel; tr_fun[k] = RF_FunSel;
            tr_oa[k]  = RF_OutASel; tr_i[k] = RF_I; tr_rdy[k] = CmdReady;
            if (Done === 1'b1) begin
                lat = k;
                err = Err;
                break;
            end
        end
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] dst,
                           input logic [2:0] src, input logic [15:0] imm);
        int   lat, exp_lat;
        logic err, exp_err;
        model(op, dst, src, imm, exp_lat, exp_err);
        send(op, dst, src, imm, lat, err);
        check($sformatf("%s.latency", tag), lat, exp_lat);
        check($sformatf("%s.err", tag), err, exp_err);
        check($sformatf("%s.rddata", tag), RdData, rd_exp);
        check($sformatf("%s.outbsel", tag), RF_OutBSel, dst);
        check_rf(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op, dst, src;
        logic [15:0] imm;
        int          lat;

        Reset = 1'b1; rf_init = 1'b1; CmdValid = 1'b0;
        CmdOp = 3'd0; CmdDst = 3'd0; CmdSrc = 3'd0; CmdImm = 16'd0;
        for (int i = 0; i < 8; i++) ref_rf[i] = 16'd0;
        rd_exp = 16'd0;
        perf_exp = 0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0; rf_init = 1'b0;
        #1;
        check("rst.ready", CmdReady, 1);
        check("rst.done", Done, 0);
        check("rst.err", Err, 0);
        check("rst.rddata", RdData, 0);
        check("rst.outbsel", RF_OutBSel, 0);
        check("rst.regsel", RF_RegSel, 4'b1111);
        check("rst.scrsel", RF_ScrSel, 4'b1111);
        check("rst.funsel", RF_FunSel, 3'b010);
        check("rst.outasel", RF_OutASel, 0);
        check("rst.rf_i", RF_I, 0);

        run_cmd("ldi", LDI, 3'd2, 3'd0, 16'hA5A5);
        check("ldi.regsel", tr_reg[1], 4'b1101);
        check("ldi.scrsel", tr_scr[1], 4'b1111);
        check("ldi.funsel", tr_fun[1], 3'b010);
        check("ldi.rf_i", tr_i[1], 16'hA5A5);

        run_cmd("ldi_r1", LDI, 3'd0, 3'd0, 16'h1234);
        run_cmd("mov", MOV, 3'd5, 3'd0, 16'h0000);
        check("mov.outasel", tr_oa[1], 3'd0);
        check("mov.scrsel", tr_scr[1], 4'b1011);
        check("mov.regsel", tr_reg[1], 4'b1111);
        check("mov.rf_i", tr_i[1], 16'h1234);

        run_cmd("ldi_r2", LDI, 3'd1, 3'd0, 16'h2222);
        run_cmd("ldi_s1", LDI, 3'd4, 3'd0, 16'h4444);
        run_cmd("swap", SWP, 3'd4, 3'd1, 16'h0000);
        check("swap.sw1_scr", tr_scr[1], 4'b1110);
        check("swap.sw1_reg", tr_reg[1], 4'b1111);
        check("swap.sw2_reg", tr_reg[2], 4'b1011);
        check("swap.sw2_scr", tr_scr[2], 4'b1111);
        check("swap.sw3_scr", tr_scr[3], 4'b0111);
        check("swap.sw3_reg", tr_reg[3], 4'b1111);
        for (int k = 1; k <= 4; k++) check($sformatf("swap.ready%0d", k), tr_rdy[k], 0);

        run_cmd("swap_tmp", SWP, 3'd7, 3'd2, 16'h0000);
        check("swap_tmp.nowrite", {tr_reg[1], tr_scr[1], tr_reg[2], tr_scr[2]}, 16'hFFFF);
        run_cmd("swap_same", SWP, 3'd3, 3'd3, 16'h0000);
        check("swap_same.nowrite", {tr_reg[1], tr_scr[1], tr_reg[2], tr_scr[2]}, 16'hFFFF);

        run_cmd("ldi_s3", LDI, 3'd6, 3'd0, 16'hBEEF);
        run_cmd("read", RD, 3'd0, 3'd6, 16'h0000);
        check("read.value", RdData, 16'hBEEF);
        run_cmd("inc_after_read", INC, 3'd0, 3'd0, 16'h0000);
        check("read.held", RdData, 16'hBEEF);

        // Abort a swap during its second write.
        CmdValid = 1'b1; CmdOp = SWP; CmdDst = 3'd2; CmdSrc = 3'd1; CmdImm = 16'd0;
        lat = 0;
        while (CmdReady !== 1'b1 && lat < 20) begin
            @(negedge Clock);
            lat++;
        end
        @(posedge Clock);
        #1 CmdValid = 1'b0;
        @(posedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        check("rstmid.regsel", RF_RegSel, 4'b1111);
        check("rstmid.scrsel", RF_ScrSel, 4'b1111);
        @(posedge Clock);
        #1 Reset = 1'b0;
        ref_rf[7] = ref_rf[1];
        rd_exp = 16'd0;
        perf_exp = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            check($sformatf("rstmid.nodone%0d", k), Done, 0);
        end
        check("rstmid.ready", CmdReady, 1);
        check("rstmid.rddata", RdData, 0);
        check("rstmid.outbsel", RF_OutBSel, 0);
        check_rf("rstmid");

        run_cmd("perf_ldi", LDI, 3'd3, 3'd0, 16'h0F0F);
        run_cmd("perf_inc", INC, 3'd3, 3'd0, 16'h0000);
        run_cmd("perf_clr", CLR, 3'd5, 3'd0, 16'h0000);
        run_cmd("perf_err", SWP, 3'd1, 3'd7, 16'h0000);
`ifdef REGFILE_CTRL_PERF_EN
        check("perf.count3", CmdCount, 3);
`endif

        for (int n = 0; n < 40; n++) begin
            op  = 3'($urandom);
            dst = 3'($urandom);
            src = 3'($urandom);
            imm = 16'($urandom);
            if (op == SWP && dst == 3'd7 && src == 3'd7) src = 3'd0;
            repeat ($urandom_range(0, 2)) @(negedge Clock);
            run_cmd($sformatf("rnd%0d_op%0d", n, op), op, dst, src, imm);
        end
`ifdef REGFILE_CTRL_PERF_EN
        check("perf.final", CmdCount, perf_exp);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
